// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: PC owner and single-outstanding fetch sequencer; define FETCH_PERF_CNT_EN for retired/stall counters
module fetch_pc_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic        instr_valid,
   output logic [31:0] instr_pc,
   output logic [31:0] pc_plus4,
   input  logic        core_ready,
   input  logic [1:0]  PCSrc,
   input  logic [31:0] ImmExt,
   input  logic [31:0] ALUResult,
   output logic        misalign_fault,
   output logic [31:0] fault_pc
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0] retired_count,
   output logic [31:0] stall_count
`endif
);
   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_REQ   = 3'd1;
   localparam logic [2:0] S_WAIT  = 3'd2;
   localparam logic [2:0] S_VALID = 3'd3;
   localparam logic [2:0] S_FAULT = 3'd4;
   logic [2:0]  r_state;
   logic [31:0] r_pc, r_instr, r_instr_pc, r_pc_plus4, r_fault_pc, w_target;
   logic        r_instr_valid, r_fault, w_accept, w_misalign;
   always_comb begin
      w_target   = (PCSrc == 2'b01) ? r_pc + ImmExt :
                   (PCSrc == 2'b10) ? (ALUResult & 32'hFFFF_FFFE) : r_pc + 32'd4;
      w_accept   = (r_state == S_VALID) && r_instr_valid && core_ready;
      w_misalign = |w_target[1:0];
   end
   assign imem_req       = (r_state == S_REQ);
   assign imem_addr      = (r_state == S_REQ) ? r_pc : 32'd0;
   assign instr          = r_instr;
   assign instr_valid    = r_instr_valid;
   assign instr_pc       = r_instr_pc;
   assign pc_plus4       = r_pc_plus4;
   assign misalign_fault = r_fault;
   assign fault_pc       = r_fault_pc;
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= S_IDLE;
         r_pc          <= RESET_PC;
         r_instr       <= NOP_INSTR;
         r_instr_valid <= 1'b0;
         r_instr_pc    <= 32'd0;
         r_pc_plus4    <= 32'd0;
         r_fault       <= 1'b0;
         r_fault_pc    <= 32'd0;
      end else begin
         case (r_state)
            S_IDLE: r_state <= S_REQ;
            S_REQ:  r_state <= S_WAIT;
            S_WAIT: if (imem_rvalid) begin
               r_instr       <= imem_rdata;
               r_instr_pc    <= r_pc;
               r_pc_plus4    <= r_pc + 32'd4;
               r_instr_valid <= 1'b1;
               r_state       <= S_VALID;
            end
            S_VALID: if (w_accept) begin
               r_instr_valid <= 1'b0;
               r_instr       <= NOP_INSTR;
               // a misaligned target leaves pc pointing at the faulting instruction
               if (w_misalign) begin
                  r_fault    <= 1'b1;
                  r_fault_pc <= w_target;
                  r_state    <= S_FAULT;
               end else begin
                  r_pc    <= w_target;
                  r_state <= S_REQ;
               end
            end
            S_FAULT: r_state <= S_FAULT;
            default: r_state <= S_IDLE;
         endcase
      end
   end
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] r_retired, r_stall;
   assign retired_count = r_retired;
   assign stall_count   = r_stall;
   always_ff @(posedge clk) begin
      if (reset) begin
         r_retired <= 32'd0;
         r_stall   <= 32'd0;
      end else begin
         if (w_accept && !w_misalign)
            r_retired <= r_retired + 32'd1;
         if ((r_state == S_WAIT && !imem_rvalid) || (r_state == S_VALID && !core_ready))
            r_stall <= r_stall + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit: directed table plus randomized transactions against a transaction-level fetch model
module tb_fetch_pc_unit;
   localparam logic [31:0] NOP = 32'h0000_0013;
   logic        clk, reset, imem_rvalid, core_ready;
   logic [31:0] imem_rdata, ImmExt, ALUResult;
   logic [1:0]  PCSrc;
   logic        imem_req, instr_valid, misalign_fault;
   logic [31:0] imem_addr, instr, instr_pc, pc_plus4, fault_pc;
   logic        d2_req, d2_valid, d2_fault;
   logic [31:0] d2_addr, d2_instr, d2_instr_pc, d2_pc_plus4, d2_fault_pc;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] retired_count, stall_count, d2_retired, d2_stall;
`endif
   int nvec = 0, nerr = 0;
   logic [31:0] m_pc, m_ret, m_stall;

   fetch_pc_unit dut (
      .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .instr(instr),
      .instr_valid(instr_valid), .instr_pc(instr_pc), .pc_plus4(pc_plus4),
      .core_ready(core_ready), .PCSrc(PCSrc), .ImmExt(ImmExt), .ALUResult(ALUResult),
      .misalign_fault(misalign_fault), .fault_pc(fault_pc)
`ifdef FETCH_PERF_CNT_EN
      , .retired_count(retired_count), .stall_count(stall_count)
`endif
   );

   fetch_pc_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
      .clk(clk), .reset(reset), .imem_req(d2_req), .imem_addr(d2_addr),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .instr(d2_instr),
      .instr_valid(d2_valid), .instr_pc(d2_instr_pc), .pc_plus4(d2_pc_plus4),
      .core_ready(core_ready), .PCSrc(PCSrc), .ImmExt(ImmExt), .ALUResult(ALUResult),
      .misalign_fault(d2_fault), .fault_pc(d2_fault_pc)
`ifdef FETCH_PERF_CNT_EN
      , .retired_count(d2_retired), .stall_count(d2_stall)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          wt;
      bit          sp;
      int          nr;
      logic [1:0]  sel;
      logic [31:0] imm;
      logic [31:0] alu;
      logic [31:0] nxt;
      bit          flt;
   } vec_t;
   vec_t tbl [10];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [1:0] sel,
                                            input logic [31:0] imm, input logic [31:0] alu);
      if (sel == 2'd1) return pc + imm;
      if (sel == 2'd2) return {alu[31:1], 1'b0};
      return pc + 32'd4;
   endfunction

   task automatic do_reset();
      reset = 1'b1; core_ready = 1'b0; imem_rvalid = 1'b0;
      tick();
      chk("rst_req", imem_req, 0);
      chk("rst_addr", imem_addr, 0);
      chk("rst_instr", instr, NOP);
      chk("rst_valid", instr_valid, 0);
      chk("rst_ipc", instr_pc, 0);
      chk("rst_pc4", pc_plus4, 0);
      chk("rst_fault", misalign_fault, 0);
      chk("rst_fpc", fault_pc, 0);
`ifdef FETCH_PERF_CNT_EN
      chk("rst_ret", retired_count, 0);
      chk("rst_stall", stall_count, 0);
`endif
      reset = 1'b0;
      tick();
      m_pc = 32'd0; m_ret = 32'd0; m_stall = 32'd0;
   endtask

   // Entered with the DUT presenting a request; leaves it at the next request or in FAULT.
   task automatic fetch_one(input int wt, input bit sp, input int nr, input logic [1:0] sel,
                            input logic [31:0] imm, input logic [31:0] alu,
                            input logic [31:0] nxt, input bit flt);
      logic [31:0] w;
      w = $urandom;
      chk("req", imem_req, 1);
      chk("addr", imem_addr, m_pc);
      chk("valid_in_req", instr_valid, 0);
      imem_rvalid = sp; imem_rdata = ~w;
      tick();
      chk("req_wait", imem_req, 0);
      for (int i = 0; i < wt; i++) begin
         imem_rvalid = 1'b0;
         tick();
         chk("req_stall", imem_req, 0);
         chk("valid_stall", instr_valid, 0);
      end
      imem_rvalid = 1'b1; imem_rdata = w;
      tick();
      imem_rvalid = 1'b0; imem_rdata = $urandom;
      chk("valid", instr_valid, 1);
      chk("instr", instr, w);
      chk("instr_pc", instr_pc, m_pc);
      chk("pc_plus4", pc_plus4, m_pc + 32'd4);
      chk("req_valid", imem_req, 0);
      for (int i = 0; i < nr; i++) begin
         core_ready = 1'b0; PCSrc = 2'($urandom); ImmExt = $urandom; ALUResult = $urandom;
         tick();
         chk("hold_instr", instr, w);
         chk("hold_ipc", instr_pc, m_pc);
         chk("hold_valid", instr_valid, 1);
         chk("hold_req", imem_req, 0);
      end
      core_ready = 1'b1; PCSrc = sel; ImmExt = imm; ALUResult = alu;
      tick();
      core_ready = 1'b0;
      m_stall += 32'(wt + nr);
      chk("acc_valid", instr_valid, 0);
      chk("acc_instr", instr, NOP);
      chk("acc_fault", misalign_fault, flt);
      if (flt) begin
         chk("fault_pc", fault_pc, nxt);
         chk("fault_req", imem_req, 0);
      end else begin
         m_pc = nxt;
         m_ret++;
      end
`ifdef FETCH_PERF_CNT_EN
      chk("retired", retired_count, m_ret);
      chk("stalls", stall_count, m_stall);
`endif
   endtask

   initial begin
      logic [1:0]  sel;
      logic [31:0] imm, alu, nxt;
      tbl[0] = '{0, 0, 0, 2'd0, 32'h0, 32'h0, 32'h4, 0};
      tbl[1] = '{0, 0, 0, 2'd0, 32'h0, 32'h0, 32'h8, 0};
      tbl[2] = '{0, 0, 0, 2'd0, 32'h0, 32'h0, 32'hC, 0};
      tbl[3] = '{0, 0, 0, 2'd0, 32'h0, 32'h0, 32'h10, 0};
      tbl[4] = '{0, 0, 0, 2'd1, 32'hFFFF_FFF8, 32'h0, 32'h8, 0};
      tbl[5] = '{0, 0, 0, 2'd2, 32'h0, 32'h101, 32'h100, 0};
      tbl[6] = '{0, 0, 5, 2'd3, 32'h0, 32'h0, 32'h104, 0};
      tbl[7] = '{4, 1, 0, 2'd1, 32'h1C, 32'h0, 32'h120, 0};
      tbl[8] = '{1, 0, 1, 2'd2, 32'h5, 32'h21, 32'h20, 0};
      tbl[9] = '{0, 0, 0, 2'd1, 32'h6, 32'h0, 32'h26, 1};
      reset = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'd0; core_ready = 1'b0;
      PCSrc = 2'd0; ImmExt = 32'd0; ALUResult = 32'd0;
      tick();
      do_reset();
      chk("d2_first_addr", d2_addr, 32'hFFFF_FFFC);
      for (int i = 0; i < 10; i++) begin
         fetch_one(tbl[i].wt, tbl[i].sp, tbl[i].nr, tbl[i].sel, tbl[i].imm, tbl[i].alu,
                   tbl[i].nxt, tbl[i].flt);
         if (i == 0) begin
            chk("d2_wrap_addr", d2_addr, 32'h0);
            chk("d2_wrap_fault", d2_fault, 0);
`ifdef FETCH_PERF_CNT_EN
            chk("d2_retired", d2_retired, 1);
`endif
         end
      end
      for (int i = 0; i < 5; i++) begin
         imem_rvalid = 1'($urandom); core_ready = 1'b1; PCSrc = 2'($urandom); ALUResult = $urandom;
         tick();
         chk("fault_hold_req", imem_req, 0);
         chk("fault_hold_flag", misalign_fault, 1);
         chk("fault_hold_pc", fault_pc, 32'h26);
         chk("fault_hold_valid", instr_valid, 0);
`ifdef FETCH_PERF_CNT_EN
         chk("fault_frz_ret", retired_count, m_ret);
         chk("fault_frz_stall", stall_count, m_stall);
`endif
      end
      do_reset();
      imem_rvalid = 1'b0;
      tick();
      reset = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
      tick();
      reset = 1'b0;
      tick();
      chk("stale_valid", instr_valid, 0);
      chk("stale_instr", instr, NOP);
      fetch_one(0, 1, 0, 2'd0, 32'h0, 32'h0, 32'h4, 0);
      for (int n = 0; n < 60; n++) begin
         sel = 2'($urandom_range(0, 3));
         imm = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
         alu = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFD);
         nxt = ref_next(m_pc, sel, imm, alu);
         fetch_one($urandom_range(0, 3), 1'($urandom), $urandom_range(0, 3), sel, imm, alu,
                   nxt, |nxt[1:0]);
         if (|nxt[1:0]) do_reset();
      end
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
